systolic_array_q15: RTL and testbench



---
 rtl/systolic_pkg.sv | 65 ++++++
 rtl/systolic_array_q15_if.sv | 34 +++
 rtl/systolic_pe.sv | 74 +++++++
 rtl/systolic_array_q15.sv | 77 +++++++
 tb/tb_systolic_array_q15.sv | 333 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/systolic_pkg.sv
// systolic_pkg
// Shared definitions for the Q1.15 output-stationary systolic array:
//   - acc_bits()     : accumulator width derivation (2*DATA_BITS + 8 guard bits)
//   - q_shift()      : Q-format rescale shift (DATA_BITS - 1)
//   - cmd_e          : per-edge command, already resolved by priority
//   - decode_cmd()   : clear_acc > compute_enable > load_weights > idle
//   - scale_narrow() : accumulator -> result word (shift, then wrap or clamp)
// Build option: define SYSTOLIC_SATURATE_EN to clamp results to the signed
// DATA_BITS range; otherwise the shifted accumulator wraps (two's complement).
package systolic_pkg;

  // scale_narrow works on fixed wide containers so one function serves any
  // DATA_BITS up to MAX_DATA_BITS (acc_bits(28) = 64 = WIDE_BITS).
  localparam int MAX_DATA_BITS = 28;
  localparam int WIDE_BITS     = 64;
  localparam int NARROW_BITS   = 32;

  typedef enum logic [1:0] {
    CMD_CLEAR,
    CMD_COMPUTE,
    CMD_LOAD,
    CMD_IDLE
  } cmd_e;

  function automatic int acc_bits(input int data_bits);
    return 2 * data_bits + 8;
  endfunction

  function automatic int q_shift(input int data_bits);
    return data_bits - 1;
  endfunction

  function automatic cmd_e decode_cmd(input logic clear_acc,
                                      input logic compute_enable,
                                      input logic load_weights);
    cmd_e cmd;
    cmd = CMD_IDLE;
    if (clear_acc)           cmd = CMD_CLEAR;
    else if (compute_enable) cmd = CMD_COMPUTE;
    else if (load_weights)   cmd = CMD_LOAD;
    return cmd;
  endfunction

  // Arithmetic right shift truncates toward minus infinity. The caller keeps
  // the low data_bits of the return value; in the clamped build the value
  // already fits, in the wrapping build the dropped bits are the wrap.
  function automatic logic signed [NARROW_BITS-1:0] scale_narrow(
      input logic signed [WIDE_BITS-1:0] acc,
      input int                          data_bits);
    logic signed [WIDE_BITS-1:0] shifted;
`ifdef SYSTOLIC_SATURATE_EN
    logic signed [WIDE_BITS-1:0] max_v;
    logic signed [WIDE_BITS-1:0] min_v;
`endif
    shifted = acc >>> q_shift(data_bits);
`ifdef SYSTOLIC_SATURATE_EN
    max_v = (64'sd1 <<< (data_bits - 1)) - 64'sd1;
    min_v = -max_v - 64'sd1;
    if (shifted > max_v)      shifted = max_v;
    else if (shifted < min_v) shifted = min_v;
`endif
    return shifted[NARROW_BITS-1:0];
  endfunction

endpackage

// File: rtl/systolic_array_q15_if.sv
// systolic_array_q15_if
// Control, operand and result bundle of the systolic array.
//   enable          : global clock enable (low -> all state holds)
//   clear_acc       : zero accumulators and operand pipelines
//   compute_enable  : shift a and b paths and accumulate
//   load_weights    : shift b path only
//   a_inputs[i]     : row i activation, enters at column 0
//   b_inputs[j]     : column j weight, enters at row 0
//   results[i][j]   : PE(i,j) accumulator rescaled to DATA_BITS
//   ready           : array idle and usable
// master = host/controller side, slave = array side.
interface systolic_array_q15_if #(
  parameter int DATA_BITS  = 16,
  parameter int ARRAY_SIZE = 4
);
  logic                        enable;
  logic                        clear_acc;
  logic                        load_weights;
  logic                        compute_enable;
  logic signed [DATA_BITS-1:0] a_inputs [ARRAY_SIZE];
  logic signed [DATA_BITS-1:0] b_inputs [ARRAY_SIZE];
  logic        [DATA_BITS-1:0] results  [ARRAY_SIZE][ARRAY_SIZE];
  logic                        ready;

  modport master (
    output enable, clear_acc, load_weights, compute_enable, a_inputs, b_inputs,
    input  results, ready
  );

  modport slave (
    input  enable, clear_acc, load_weights, compute_enable, a_inputs, b_inputs,
    output results, ready
  );
endinterface

// File: rtl/systolic_pe.sv
// systolic_pe
// One multiply-accumulate cell of the output-stationary array.
//   clk, reset : clock and asynchronous active-high reset
//   enable     : clock enable; low -> every register holds
//   cmd        : priority-resolved command for this edge
//   a_in, b_in : operands from the left / upper neighbour (or array edge)
//   a_out      : registered activation passed to the right
//   b_out      : registered weight passed downward
//   result     : accumulator rescaled and narrowed (combinational)
// Result narrowing obeys SYSTOLIC_SATURATE_EN (see systolic_pkg).
module systolic_pe
  import systolic_pkg::*;
#(
  parameter int DATA_BITS = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        enable,
  input  cmd_e                        cmd,
  input  logic signed [DATA_BITS-1:0] a_in,
  input  logic signed [DATA_BITS-1:0] b_in,
  output logic signed [DATA_BITS-1:0] a_out,
  output logic signed [DATA_BITS-1:0] b_out,
  output logic        [DATA_BITS-1:0] result
);
  localparam int ACC_BITS = acc_bits(DATA_BITS);

  logic signed [DATA_BITS-1:0]   a_reg;
  logic signed [DATA_BITS-1:0]   b_reg;
  logic signed [ACC_BITS-1:0]    acc_reg;
  logic signed [2*DATA_BITS-1:0] product;
  logic signed [ACC_BITS-1:0]    product_ext;
  logic signed [WIDE_BITS-1:0]   acc_wide;
  logic signed [NARROW_BITS-1:0] scaled;
  logic [NARROW_BITS-DATA_BITS-1:0] unused_scaled_hi;

  // Full-precision signed product, sign-extended into the guard bits.
  assign product     = a_in * b_in;
  assign product_ext = ACC_BITS'(product);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_reg   <= '0;
      b_reg   <= '0;
      acc_reg <= '0;
    end else if (enable) begin
      case (cmd)
        CMD_CLEAR: begin
          a_reg   <= '0;
          b_reg   <= '0;
          acc_reg <= '0;
        end
        CMD_COMPUTE: begin
          a_reg   <= a_in;
          b_reg   <= b_in;
          acc_reg <= acc_reg + product_ext;
        end
        CMD_LOAD: begin
          b_reg <= b_in;
        end
        default: begin
        end
      endcase
    end
  end

  assign acc_wide         = WIDE_BITS'(acc_reg);
  assign scaled           = scale_narrow(acc_wide, DATA_BITS);
  assign result           = scaled[DATA_BITS-1:0];
  assign unused_scaled_hi = scaled[NARROW_BITS-1:DATA_BITS];

  assign a_out = a_reg;
  assign b_out = b_reg;
endmodule

// File: rtl/systolic_array_q15.sv
// systolic_array_q15
// ARRAY_SIZE x ARRAY_SIZE output-stationary grid of Q1.15 MAC cells computing
// C = A*B from skewed operand streams. Activations move right, weights move
// down; PE(i,j) holds C[i][j].
//   clk   : single rising-edge clock
//   reset : asynchronous active-high, clears every register
//   bus   : systolic_array_q15_if.slave (controls, operands, results, ready)
// Build option: SYSTOLIC_SATURATE_EN clamps results instead of wrapping.
module systolic_array_q15
  import systolic_pkg::*;
#(
  parameter int DATA_BITS  = 16,
  parameter int ARRAY_SIZE = 4
) (
  input logic                 clk,
  input logic                 reset,
  systolic_array_q15_if.slave bus
);
  cmd_e cmd;
  logic ready_reg;

  // Registered operand outputs of each PE, consumed by the right / lower neighbour.
  logic signed [DATA_BITS-1:0] a_link [ARRAY_SIZE][ARRAY_SIZE];
  logic signed [DATA_BITS-1:0] b_link [ARRAY_SIZE][ARRAY_SIZE];

  assign cmd = decode_cmd(bus.clear_acc, bus.compute_enable, bus.load_weights);

  // ready reflects the last enabled edge: idle -> 1, any command -> 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ready_reg <= 1'b0;
    end else if (bus.enable) begin
      ready_reg <= (cmd == CMD_IDLE);
    end
  end

  assign bus.ready = ready_reg;

  genvar gi, gj;
  generate
    for (gi = 0; gi < ARRAY_SIZE; gi++) begin : g_row
      for (gj = 0; gj < ARRAY_SIZE; gj++) begin : g_col
        logic signed [DATA_BITS-1:0] a_src;
        logic signed [DATA_BITS-1:0] b_src;
        logic        [DATA_BITS-1:0] pe_result;

        if (gj == 0) begin : g_a_edge
          assign a_src = bus.a_inputs[gi];
        end else begin : g_a_chain
          assign a_src = a_link[gi][gj-1];
        end

        if (gi == 0) begin : g_b_edge
          assign b_src = bus.b_inputs[gj];
        end else begin : g_b_chain
          assign b_src = b_link[gi-1][gj];
        end

        systolic_pe #(
          .DATA_BITS(DATA_BITS)
        ) u_pe (
          .clk    (clk),
          .reset  (reset),
          .enable (bus.enable),
          .cmd    (cmd),
          .a_in   (a_src),
          .b_in   (b_src),
          .a_out  (a_link[gi][gj]),
          .b_out  (b_link[gi][gj]),
          .result (pe_result)
        );

        assign bus.results[gi][gj] = pe_result;
      end
    end
  endgenerate
endmodule

// File: tb/tb_systolic_array_q15.sv
// tb_systolic_array_q15
// Directed bench for systolic_array_q15 (4x4, Q1.15). Expected result grids
// are computed here from the matrix definitions, queued when stimulus is
// driven and popped when the results are sampled.
module tb_systolic_array_q15;
  localparam int DB = 16;
  localparam int N  = 4;

  typedef struct {
    string           tag;
    int              row;
    int              col;
    logic [DB-1:0]   value;
  } exp_t;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  systolic_array_q15_if #(.DATA_BITS(DB), .ARRAY_SIZE(N)) bus ();

  systolic_array_q15 #(
    .DATA_BITS (DB),
    .ARRAY_SIZE(N)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  exp_t              sb [$];
  int                vectors     = 0;
  int                miscompares = 0;
  logic signed [15:0] mat_a [N][N];
  logic signed [15:0] mat_b [N][N];
  logic [DB-1:0]      exp_grid [N][N];

  // Reference rescale: floor(sum / 2^15), then clamp or wrap to 16 bits.
  function automatic logic [15:0] ref_q15(input longint sum);
    longint sh;
    sh = sum >>> 15;
`ifdef SYSTOLIC_SATURATE_EN
    if (sh > 32767)  return 16'h7FFF;
    if (sh < -32768) return 16'h8000;
`endif
    return sh[15:0];
  endfunction

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    bus.enable         = 1'b1;
    bus.clear_acc      = 1'b0;
    bus.load_weights   = 1'b0;
    bus.compute_enable = 1'b0;
    for (int i = 0; i < N; i++) begin
      bus.a_inputs[i] = '0;
      bus.b_inputs[i] = '0;
    end
  endtask

  task automatic zero_grid();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        exp_grid[i][j] = '0;
  endtask

  task automatic expect_grid(input string tag);
    exp_t e;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        e.tag   = tag;
        e.row   = i;
        e.col   = j;
        e.value = exp_grid[i][j];
        sb.push_back(e);
      end
    end
  endtask

  task automatic compare_grid(input string tag);
    exp_t          e;
    logic [DB-1:0] obs;
    int            bad;
    bad = 0;
    for (int n = 0; n < N * N; n++) begin
      vectors++;
      assert (sb.size() > 0) else begin
        miscompares++;
        bad++;
        $error("FAIL %s scoreboard observed=empty expected=entry", tag);
      end
      if (sb.size() > 0) begin
        e   = sb.pop_front();
        obs = bus.results[e.row][e.col];
        assert (obs === e.value) else begin
          miscompares++;
          bad++;
          $error("FAIL %s results[%0d][%0d] observed=%04h expected=%04h",
                 e.tag, e.row, e.col, obs, e.value);
        end
      end
    end
    $display("txn %-16s %0d cells compared, %0d wrong", tag, N * N, bad);
  endtask

  task automatic check_ready(input string tag, input logic exp);
    vectors++;
    assert (bus.ready === exp) else begin
      miscompares++;
      $error("FAIL %s ready observed=%0b expected=%0b", tag, bus.ready, exp);
    end
  endtask

  task automatic do_clear();
    drive_idle();
    bus.clear_acc = 1'b1;
    cycle();
    drive_idle();
  endtask

  // Skewed feed of mat_a * mat_b (K = N). At cycle hold_at two enable-low
  // cycles with conflicting commands and junk operands are inserted.
  task automatic run_product(input string tag, input int hold_at);
    longint s;
    int     kk;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        s = 0;
        for (int k = 0; k < N; k++)
          s += longint'(mat_a[i][k]) * longint'(mat_b[k][j]);
        exp_grid[i][j] = ref_q15(s);
      end
    end
    expect_grid(tag);
    for (int t = 0; t < N + 2 * (N - 1); t++) begin
      if (t == hold_at) begin
        bus.enable         = 1'b0;
        bus.clear_acc      = 1'b1;
        bus.compute_enable = 1'b1;
        for (int i = 0; i < N; i++) begin
          bus.a_inputs[i] = 16'($urandom);
          bus.b_inputs[i] = 16'($urandom);
        end
        cycle();
        cycle();
        check_ready({tag, "_hold"}, 1'b0);
        bus.enable    = 1'b1;
        bus.clear_acc = 1'b0;
      end
      bus.compute_enable = 1'b1;
      for (int i = 0; i < N; i++) begin
        kk = t - i;
        bus.a_inputs[i] = (kk >= 0 && kk < N) ? mat_a[i][kk] : 16'sd0;
        bus.b_inputs[i] = (kk >= 0 && kk < N) ? mat_b[kk][i] : 16'sd0;
      end
      cycle();
    end
    drive_idle();
    cycle();
    compare_grid(tag);
    check_ready({tag, "_ready"}, 1'b1);
  endtask

  initial begin
    // ---- reset state ----
    reset = 1'b1;
    drive_idle();
    cycle();
    cycle();
    zero_grid();
    expect_grid("reset");
    compare_grid("reset");
    check_ready("reset_ready", 1'b0);
    reset = 1'b0;
    cycle();
    check_ready("first_idle", 1'b1);

    // ---- single MAC, +0.5 * +0.5 ----
    do_clear();
    check_ready("clear_ready", 1'b0);
    bus.compute_enable = 1'b1;
    bus.a_inputs[0]    = 16'sh4000;
    bus.b_inputs[0]    = 16'sh4000;
    zero_grid();
    exp_grid[0][0] = 16'h2000;
    expect_grid("mac_pos");
    cycle();
    compare_grid("mac_pos");
    check_ready("mac_ready", 1'b0);

    // ---- single MAC, -0.5 * +0.5 ----
    do_clear();
    bus.compute_enable = 1'b1;
    bus.a_inputs[0]    = 16'shC000;
    bus.b_inputs[0]    = 16'sh4000;
    zero_grid();
    exp_grid[0][0] = 16'hE000;
    expect_grid("mac_neg");
    cycle();
    compare_grid("mac_neg");

    // ---- identity product: A = 0.5*I ----
    do_clear();
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        mat_a[i][j] = (i == j) ? 16'sh4000 : 16'sh0000;
        mat_b[i][j] = 16'(16'h1000 + (i * N + j) * 16'h0300);
      end
    end
    run_product("identity", -1);

    // ---- random full-range product with an enable-low hold inserted ----
    do_clear();
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        mat_a[i][j] = 16'($urandom);
        mat_b[i][j] = 16'($urandom);
      end
    end
    run_product("random_hold", 4);

    // ---- enable low with a clear pending: nothing changes ----
    bus.enable    = 1'b0;
    bus.clear_acc = 1'b1;
    cycle();
    cycle();
    expect_grid("enable_low");
    compare_grid("enable_low");
    check_ready("enable_low_ready", 1'b1);

    // ---- clear_acc beats compute_enable ----
    drive_idle();
    bus.clear_acc      = 1'b1;
    bus.compute_enable = 1'b1;
    bus.a_inputs[0]    = 16'sh4000;
    bus.b_inputs[0]    = 16'sh4000;
    cycle();
    zero_grid();
    expect_grid("clear_prio");
    compare_grid("clear_prio");
    check_ready("clear_prio_ready", 1'b0);

    // ---- saturation / wrap on PE(0,0) ----
    do_clear();
    bus.compute_enable = 1'b1;
    bus.a_inputs[0]    = 16'sh7FFF;
    bus.b_inputs[0]    = 16'sh7FFF;
    repeat (4) cycle();
    drive_idle();
    zero_grid();
    exp_grid[0][0] = ref_q15(4 * 64'sd32767 * 64'sd32767);
    expect_grid("saturate");
    compare_grid("saturate");

    // ---- load_weights shifts b only ----
    do_clear();
    bus.compute_enable = 1'b1;
    bus.a_inputs[0]    = 16'sh4000;
    bus.b_inputs[0]    = 16'sh4000;
    cycle();
    drive_idle();
    bus.load_weights = 1'b1;
    bus.b_inputs[0]  = 16'sh2468;
    bus.b_inputs[1]  = 16'sh1000;
    bus.b_inputs[2]  = 16'sh0800;
    bus.b_inputs[3]  = 16'sh0400;
    bus.a_inputs[1]  = 16'sh4000;
    cycle();
    zero_grid();
    exp_grid[0][0] = 16'h2000;
    expect_grid("load_hold");
    compare_grid("load_hold");
    check_ready("load_ready", 1'b0);
    // PE(1,0) now sees the loaded weight, PE(0,1) the held activation.
    drive_idle();
    bus.compute_enable = 1'b1;
    bus.a_inputs[1]    = 16'sh4000;
    bus.b_inputs[1]    = 16'sh4000;
    cycle();
    drive_idle();
    zero_grid();
    exp_grid[0][0] = 16'h2000;
    exp_grid[0][1] = 16'h2000;
    exp_grid[1][0] = 16'h1234;
    expect_grid("load_shift");
    compare_grid("load_shift");

    // ---- asynchronous reset mid-compute ----
    do_clear();
    bus.compute_enable = 1'b1;
    for (int i = 0; i < N; i++) begin
      bus.a_inputs[i] = 16'sh3000;
      bus.b_inputs[i] = 16'sh5000;
    end
    cycle();
    cycle();
    reset = 1'b1;
    #2;
    zero_grid();
    expect_grid("async_reset");
    compare_grid("async_reset");
    check_ready("async_reset_ready", 1'b0);
    drive_idle();
    cycle();
    reset = 1'b0;
    cycle();
    check_ready("post_reset_idle", 1'b1);
    expect_grid("post_reset");
    compare_grid("post_reset");

    vectors++;
    assert (sb.size() == 0) else begin
      miscompares++;
      $error("FAIL scoreboard_drain observed=%0d expected=0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Bound on total run time so a stuck bench still ends with a report.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
    $fatal(1, "timeout");
  end
endmodule
